// File: rtl/riskv_pkg.sv
// Shared encodings and the EX/MEM register layout used by the execute-to-memory boundary.
package riskv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    // Must stay in step with the comparison codes the ALU decodes.
    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } branch_f3_e;

    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  mem_write;
        result_src_e           result_src;
        logic [2:0]            funct3;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       alu_result;
        logic [XLEN-1:0]       pc_plus4;
        logic [XLEN-1:0]       write_data;
    } ex_mem_t;

    function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
        return |addr_lsbs;
    endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// Bundle between the EX stage, the EX/MEM register, the memory stage and the fetch redirect path.
interface ex_mem_stage_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
);
    logic                      valid_i;
    logic [DATA_WIDTH-1:0]     pc_i;
    logic [DATA_WIDTH-1:0]     pcPlus4_i;
    logic [DATA_WIDTH-1:0]     immExt_i;
    logic [DATA_WIDTH-1:0]     ALUResult_i;
    logic                      branchTaken_i;
    logic                      isBranch_i;
    logic                      isJal_i;
    logic                      isJalr_i;
    logic                      regWrite_i;
    logic                      memWrite_i;
    logic [1:0]                resultSrc_i;
    logic [2:0]                funct3_i;
    logic [REG_ADDR_WIDTH-1:0] rd_i;
    logic [DATA_WIDTH-1:0]     writeData_i;
    logic                      stall_i;
    logic                      flush_i;

    logic                      valid_o;
    logic [DATA_WIDTH-1:0]     ALUResult_o;
    logic [DATA_WIDTH-1:0]     pcPlus4_o;
    logic [DATA_WIDTH-1:0]     writeData_o;
    logic                      regWrite_o;
    logic                      memWrite_o;
    logic [1:0]                resultSrc_o;
    logic [2:0]                funct3_o;
    logic [REG_ADDR_WIDTH-1:0] rd_o;
    logic                      redirect_o;
    logic [DATA_WIDTH-1:0]     target_o;
    logic                      flushFront_o;
    logic                      misalign_o;
    logic [CNT_WIDTH-1:0]      branchCount_o;
    logic [CNT_WIDTH-1:0]      takenCount_o;

    modport slave (
        input  valid_i, pc_i, pcPlus4_i, immExt_i, ALUResult_i, branchTaken_i,
               isBranch_i, isJal_i, isJalr_i, regWrite_i, memWrite_i, resultSrc_i,
               funct3_i, rd_i, writeData_i, stall_i, flush_i,
        output valid_o, ALUResult_o, pcPlus4_o, writeData_o, regWrite_o, memWrite_o,
               resultSrc_o, funct3_o, rd_o, redirect_o, target_o, flushFront_o,
               misalign_o, branchCount_o, takenCount_o
    );

    modport master (
        output valid_i, pc_i, pcPlus4_i, immExt_i, ALUResult_i, branchTaken_i,
               isBranch_i, isJal_i, isJalr_i, regWrite_i, memWrite_i, resultSrc_i,
               funct3_i, rd_i, writeData_i, stall_i, flush_i,
        input  valid_o, ALUResult_o, pcPlus4_o, writeData_o, regWrite_o, memWrite_o,
               resultSrc_o, funct3_o, rd_o, redirect_o, target_o, flushFront_o,
               misalign_o, branchCount_o, takenCount_o
    );
endinterface

// File: rtl/ex_mem_stage_branch_resolve.sv
// Combinational control-transfer resolution: target PC, take decision and alignment check.
module branch_resolve
    import riskv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic [DATA_WIDTH-1:0] imm_i,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    input  logic                  branch_taken_i,
    input  logic                  is_branch_i,
    input  logic                  is_jal_i,
    input  logic                  is_jalr_i,
    output logic [DATA_WIDTH-1:0] target_o,
    output logic                  take_o,
    output logic                  misalign_o,
    output logic                  redirect_o
);
    always_comb begin
        // JALR clears bit 0; bit 1 is left alone so a misaligned JALR is still caught.
        if (is_jalr_i) begin
            target_o = {alu_result_i[DATA_WIDTH-1:1], 1'b0};
        end else begin
            target_o = pc_i + imm_i;
        end
        take_o     = valid_i & (is_jal_i | is_jalr_i | (is_branch_i & branch_taken_i));
        misalign_o = take_o & is_misaligned(target_o[1:0]);
        redirect_o = take_o & ~misalign_o;
    end
endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with redirect generation, wrong-path squash and branch statistics.
module ex_mem_stage
    import riskv_pkg::*;
#(
    parameter int DATA_WIDTH     = XLEN,
    parameter int REG_ADDR_WIDTH = REG_ADDR_W,
    parameter int CNT_WIDTH      = 32
) (
    input logic           clk,
    input logic           rst,
    ex_mem_stage_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    ex_mem_t               ex_mem_q, ex_mem_d;
    logic                  redirect_q;
    logic                  misalign_q;
    logic [DATA_WIDTH-1:0] target_q;
    logic [CNT_WIDTH-1:0]  branch_cnt_q, branch_cnt_d;
    logic [CNT_WIDTH-1:0]  taken_cnt_q, taken_cnt_d;

    logic                  squash;
    logic                  eff_valid;
    logic [DATA_WIDTH-1:0] target;
    logic                  take;
    logic                  misalign;
    logic                  redirect_d;

    // The instruction sitting in EX while a redirect leaves is on the wrong path.
    assign squash    = redirect_q & ~bus.stall_i;
    assign eff_valid = bus.valid_i & ~squash;

    branch_resolve #(.DATA_WIDTH(DATA_WIDTH)) u_resolve (
        .valid_i        (eff_valid),
        .pc_i           (bus.pc_i),
        .imm_i          (bus.immExt_i),
        .alu_result_i   (bus.ALUResult_i),
        .branch_taken_i (bus.branchTaken_i),
        .is_branch_i    (bus.isBranch_i),
        .is_jal_i       (bus.isJal_i),
        .is_jalr_i      (bus.isJalr_i),
        .target_o       (target),
        .take_o         (take),
        .misalign_o     (misalign),
        .redirect_o     (redirect_d)
    );

    always_comb begin
        ex_mem_d            = '0;
        ex_mem_d.valid      = eff_valid;
        // A misaligned control transfer must not retire any architectural side effect.
        ex_mem_d.reg_write  = bus.regWrite_i & eff_valid & ~misalign;
        ex_mem_d.mem_write  = bus.memWrite_i & eff_valid & ~misalign;
        ex_mem_d.result_src = result_src_e'(bus.resultSrc_i);
        ex_mem_d.funct3     = bus.funct3_i;
        ex_mem_d.rd         = bus.rd_i;
        ex_mem_d.alu_result = bus.ALUResult_i;
        ex_mem_d.pc_plus4   = bus.pcPlus4_i;
        ex_mem_d.write_data = bus.writeData_i;

        branch_cnt_d = branch_cnt_q;
        taken_cnt_d  = taken_cnt_q;
        if (eff_valid & bus.isBranch_i) begin
            branch_cnt_d = branch_cnt_q + CNT_ONE;
            if (bus.branchTaken_i) begin
                taken_cnt_d = taken_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_mem_q     <= '0;
            redirect_q   <= 1'b0;
            misalign_q   <= 1'b0;
            target_q     <= '0;
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else if (bus.flush_i) begin
            ex_mem_q.valid     <= 1'b0;
            ex_mem_q.reg_write <= 1'b0;
            ex_mem_q.mem_write <= 1'b0;
            redirect_q         <= 1'b0;
            misalign_q         <= 1'b0;
        end else if (!bus.stall_i) begin
            ex_mem_q     <= ex_mem_d;
            redirect_q   <= redirect_d;
            misalign_q   <= misalign;
            target_q     <= target;
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
        end
    end

    assign bus.valid_o       = ex_mem_q.valid;
    assign bus.regWrite_o    = ex_mem_q.reg_write;
    assign bus.memWrite_o    = ex_mem_q.mem_write;
    assign bus.resultSrc_o   = ex_mem_q.result_src;
    assign bus.funct3_o      = ex_mem_q.funct3;
    assign bus.rd_o          = ex_mem_q.rd;
    assign bus.ALUResult_o   = ex_mem_q.alu_result;
    assign bus.pcPlus4_o     = ex_mem_q.pc_plus4;
    assign bus.writeData_o   = ex_mem_q.write_data;
    assign bus.redirect_o    = redirect_q;
    assign bus.flushFront_o  = redirect_q;
    assign bus.target_o      = target_q;
    assign bus.misalign_o    = misalign_q;
    assign bus.branchCount_o = branch_cnt_q;
    assign bus.takenCount_o  = taken_cnt_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed scoreboard bench for ex_mem_stage built with 4-bit statistics counters.
module tb_ex_mem_stage;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 4;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   txn;

    typedef struct {
        bit          valid;
        bit          rw;
        bit          mw;
        bit          redir;
        logic [31:0] tgt;
        bit          mis;
        int          bc;
        int          tc;
        bit          cd;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] rd;
    } exp_t;

    exp_t exp_q[$];

    ex_mem_stage_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW)) bus ();

    ex_mem_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic nop_in();
        bus.valid_i       = 1'b0;
        bus.pc_i          = '0;
        bus.pcPlus4_i     = '0;
        bus.immExt_i      = '0;
        bus.ALUResult_i   = '0;
        bus.branchTaken_i = 1'b0;
        bus.isBranch_i    = 1'b0;
        bus.isJal_i       = 1'b0;
        bus.isJalr_i      = 1'b0;
        bus.regWrite_i    = 1'b0;
        bus.memWrite_i    = 1'b0;
        bus.resultSrc_i   = 2'b00;
        bus.funct3_i      = 3'b000;
        bus.rd_i          = '0;
        bus.writeData_i   = '0;
        bus.stall_i       = 1'b0;
        bus.flush_i       = 1'b0;
    endtask

    // Queue the outputs expected after the coming edge, then move to the next drive point.
    task automatic push(input bit v, input bit rw, input bit mw, input bit redir,
                        input logic [31:0] tgt, input bit mis, input int bc, input int tc,
                        input bit cd, input logic [31:0] alu, input logic [31:0] wd,
                        input logic [31:0] rd);
        exp_t e;
        e.valid = v;   e.rw  = rw;  e.mw  = mw; e.redir = redir; e.tgt = tgt;
        e.mis   = mis; e.bc  = bc;  e.tc  = tc; e.cd    = cd;    e.alu = alu;
        e.wd    = wd;  e.rd  = rd;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: compares every registered output one step after each active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                txn++;
                $display("txn %0d valid=%0b rw=%0b mw=%0b redir=%0b tgt=0x%0h mis=%0b bc=%0d tc=%0d",
                         txn, bus.valid_o, bus.regWrite_o, bus.memWrite_o, bus.redirect_o,
                         bus.target_o, bus.misalign_o, bus.branchCount_o, bus.takenCount_o);
                chk("valid_o", 32'(bus.valid_o), 32'(e.valid));
                chk("regWrite_o", 32'(bus.regWrite_o), 32'(e.rw));
                chk("memWrite_o", 32'(bus.memWrite_o), 32'(e.mw));
                chk("redirect_o", 32'(bus.redirect_o), 32'(e.redir));
                chk("flushFront_o", 32'(bus.flushFront_o), 32'(e.redir));
                chk("misalign_o", 32'(bus.misalign_o), 32'(e.mis));
                chk("branchCount_o", 32'(bus.branchCount_o), 32'(e.bc % 16));
                chk("takenCount_o", 32'(bus.takenCount_o), 32'(e.tc % 16));
                if (e.redir) chk("target_o", bus.target_o, e.tgt);
                if (e.cd) begin
                    chk("ALUResult_o", bus.ALUResult_o, e.alu);
                    chk("writeData_o", bus.writeData_o, e.wd);
                    chk("rd_o", 32'(bus.rd_o), e.rd);
                end
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        txn      = 0;
        rst      = 1'b1;
        nop_in();
        #12;
        chk("reset valid_o", 32'(bus.valid_o), 32'd0);
        chk("reset redirect_o", 32'(bus.redirect_o), 32'd0);
        chk("reset branchCount_o", 32'(bus.branchCount_o), 32'd0);
        chk("reset target_o", bus.target_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // BEQ taken, then the wrong-path instruction behind it, then a not-taken BNE
        nop_in(); bus.valid_i = 1; bus.isBranch_i = 1; bus.branchTaken_i = 1;
        bus.pc_i = 32'h100; bus.pcPlus4_i = 32'h104; bus.immExt_i = 32'h20;
        push(1, 0, 0, 1, 32'h120, 0, 1, 1, 1, 32'h0, 32'h0, 0);
        nop_in(); bus.valid_i = 1; bus.regWrite_i = 1; bus.ALUResult_i = 32'h55; bus.rd_i = 3;
        push(0, 0, 0, 0, 32'h0, 0, 1, 1, 1, 32'h55, 32'h0, 3);
        nop_in(); bus.valid_i = 1; bus.isBranch_i = 1; bus.funct3_i = 3'b001;
        bus.pc_i = 32'h200; bus.immExt_i = 32'h40;
        push(1, 0, 0, 0, 32'h0, 0, 2, 1, 1, 32'h0, 32'h0, 0);

        // JALR to 0x2003 -> 0x2002, misaligned: no redirect, no register write
        nop_in(); bus.valid_i = 1; bus.isJalr_i = 1; bus.ALUResult_i = 32'h2003;
        bus.resultSrc_i = 2'b10; bus.rd_i = 1; bus.regWrite_i = 1;
        bus.pc_i = 32'h300; bus.pcPlus4_i = 32'h304;
        push(1, 0, 0, 0, 32'h0, 1, 2, 1, 1, 32'h2003, 32'h0, 1);
        nop_in(); bus.valid_i = 1; bus.regWrite_i = 1; bus.ALUResult_i = 32'h7; bus.rd_i = 2;
        push(1, 1, 0, 0, 32'h0, 0, 2, 1, 1, 32'h7, 32'h0, 2);

        // JAL aligned, then three stalled cycles holding the redirect
        nop_in(); bus.valid_i = 1; bus.isJal_i = 1; bus.regWrite_i = 1; bus.rd_i = 1;
        bus.resultSrc_i = 2'b10; bus.pc_i = 32'h400; bus.pcPlus4_i = 32'h404; bus.immExt_i = 32'h10;
        push(1, 1, 0, 1, 32'h410, 0, 2, 1, 1, 32'h0, 32'h0, 1);
        nop_in(); bus.valid_i = 1; bus.regWrite_i = 1; bus.ALUResult_i = 32'h99; bus.rd_i = 4;
        bus.stall_i = 1;
        repeat (3) push(1, 1, 0, 1, 32'h410, 0, 2, 1, 1, 32'h0, 32'h0, 1);
        bus.stall_i = 0;
        push(0, 0, 0, 0, 32'h0, 0, 2, 1, 1, 32'h99, 32'h0, 4);
        nop_in(); bus.valid_i = 1; bus.regWrite_i = 1; bus.ALUResult_i = 32'hAA; bus.rd_i = 5;
        push(1, 1, 0, 0, 32'h0, 0, 2, 1, 1, 32'hAA, 32'h0, 5);

        // Store held by a stall, then released
        nop_in(); bus.valid_i = 1; bus.memWrite_i = 1; bus.ALUResult_i = 32'h800;
        bus.writeData_i = 32'hDEADBEEF; bus.funct3_i = 3'b010; bus.stall_i = 1;
        push(1, 1, 0, 0, 32'h0, 0, 2, 1, 1, 32'hAA, 32'h0, 5);
        bus.stall_i = 0;
        push(1, 0, 1, 0, 32'h0, 0, 2, 1, 1, 32'h800, 32'hDEADBEEF, 0);

        // Flush together with stall, with a taken branch present that must not count
        nop_in(); bus.valid_i = 1; bus.isBranch_i = 1; bus.branchTaken_i = 1;
        bus.pc_i = 32'h600; bus.immExt_i = 32'h8; bus.stall_i = 1; bus.flush_i = 1;
        push(0, 0, 0, 0, 32'h0, 0, 2, 1, 0, 32'h0, 32'h0, 0);

        // Not-taken branches until the 4-bit branch counter wraps to zero
        for (int i = 0; i < 14; i++) begin
            nop_in(); bus.valid_i = 1; bus.isBranch_i = 1; bus.funct3_i = 3'b001;
            bus.pc_i = 32'h700 + 32'(4 * i); bus.immExt_i = 32'h100;
            push(1, 0, 0, 0, 32'h0, 0, 3 + i, 1, 1, 32'h0, 32'h0, 0);
        end

        // Taken branch whose target wraps past 2^32
        nop_in(); bus.valid_i = 1; bus.isBranch_i = 1; bus.branchTaken_i = 1;
        bus.pc_i = 32'hFFFF_FFF0; bus.immExt_i = 32'h20;
        push(1, 0, 0, 1, 32'h10, 0, 1, 2, 1, 32'h0, 32'h0, 0);
        nop_in();

        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset between edges
        #2 rst = 1'b1;
        #1;
        chk("async valid_o", 32'(bus.valid_o), 32'd0);
        chk("async redirect_o", 32'(bus.redirect_o), 32'd0);
        chk("async flushFront_o", 32'(bus.flushFront_o), 32'd0);
        chk("async target_o", bus.target_o, 32'd0);
        chk("async branchCount_o", 32'(bus.branchCount_o), 32'd0);
        chk("async takenCount_o", 32'(bus.takenCount_o), 32'd0);
        chk("async regWrite_o", 32'(bus.regWrite_o), 32'd0);
        chk("async misalign_o", 32'(bus.misalign_o), 32'd0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Pipeline stage directly downstream of the ALU. Consumes ALUResult_o and branchTaken_o each cycle.
- Resolves branch and jump redirects, and detects misaligned targets.
- Holds the EX/MEM pipeline register, with stall, flush and wrong-path squash.
- Keeps branch statistics counters. Feeds the memory stage, plus the fetch PC mux and the IF/ID and ID/EX flush inputs.

Parameters:
DATA_WIDTH, 32, datapath and PC width
REG_ADDR_WIDTH, 5, destination register index width
CNT_WIDTH, 32, width of the statistics counters

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
valid_i  input  1  instruction present in EX
pc_i  input  DATA_WIDTH  PC of the EX instruction
pcPlus4_i  input  DATA_WIDTH  pc_i+4
immExt_i  input  DATA_WIDTH  sign-extended immediate
ALUResult_i  input  DATA_WIDTH  ALU result
branchTaken_i  input  1  ALU branch comparison result
isBranch_i  input  1  conditional branch
isJal_i  input  1  JAL
isJalr_i  input  1  JALR
regWrite_i  input  1  writes rd
memWrite_i  input  1  store
resultSrc_i  input  2  writeback select: 00 ALU, 01 memory, 10 PC+4
funct3_i  input  3  memory access size/sign
rd_i  input  REG_ADDR_WIDTH  destination register
writeData_i  input  DATA_WIDTH  store data
stall_i  input  1  memory stage not ready; hold everything
flush_i  input  1  late trap flush; kill the EX/MEM contents
valid_o  output  1  EX/MEM slot valid
ALUResult_o, pcPlus4_o, writeData_o  output  DATA_WIDTH  registered copies
regWrite_o, memWrite_o  output  1  registered, gated by valid
resultSrc_o  output  2  registered
funct3_o  output  3  registered
rd_o  output  REG_ADDR_WIDTH  registered
redirect_o  output  1  fetch must load target_o
target_o  output  DATA_WIDTH  redirect PC
flushFront_o  output  1  clear IF/ID and ID/EX; equals redirect_o
misalign_o  output  1  registered, sticky-for-one-capture misaligned-target flag
branchCount_o, takenCount_o  output  CNT_WIDTH  statistics counters

Behaviour:
- Reset (async, rst=1): every output is 0, including both counters. The internal squash flag is 0.
- Update priority at each rising edge: rst > flush_i > stall_i > normal capture.

Effective valid:
- eff_valid = valid_i & ~squash.
- squash = redirect_o & ~stall_i. The instruction presented while a redirect is leaving is wrong-path and is killed.

Target computation (combinational):
- Branch and JAL: pc_i + immExt_i.
- JALR: ALUResult_i with bit 0 forced to 0.
- Arithmetic is modulo 2^DATA_WIDTH; wrap-around is silent.

take:
- take = eff_valid & (isJal_i | isJalr_i | (isBranch_i & branchTaken_i)).
- A misaligned target means target[1:0] != 0.
- take with an aligned target: the next edge sets redirect_o=1 and target_o=target.
- take with a misaligned target: no redirect. misalign_o=1, and the slot is captured with regWrite_o=0 and memWrite_o=0.

Normal capture (stall_i=0, flush_i=0):
- All registered fields load.
- valid_o <= eff_valid.
- regWrite_o and memWrite_o are ANDed with eff_valid.
- redirect_o, flushFront_o and misalign_o are 1-cycle pulses: they are cleared on the next non-stalled edge unless re-triggered.

stall_i=1:
- Every register holds, including redirect_o, target_o and the counters.
- A pending redirect therefore persists until the first non-stalled cycle.

flush_i=1:
- valid_o, regWrite_o, memWrite_o, redirect_o, flushFront_o and misalign_o are cleared.
- Data fields are don't-care. The counters are not incremented.

Counters:
- branchCount_o increments on a normal capture with eff_valid & isBranch_i.
- takenCount_o additionally requires branchTaken_i.
- Both wrap to 0 on overflow.

Simultaneous events:
- flush_i together with stall_i: the flush wins.
- Reset asserted mid-stall clears everything immediately, without a clock edge.

Decomposition:
- Shared package (riskv_pkg):
  - resultSrc encodings: RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10.
  - funct3 branch codes matching the ALU: BEQ=000, BNE=001, BLT=100, BGE=101, BLTU=110, BGEU=111.
  - A packed ex_mem_t struct holding the registered fields.
- One sub-module, branch_resolve: combinational target, take and misalign computation. The counters and registers stay in ex_mem_stage.

Test Plan:
1. BEQ taken: valid_i=1, isBranch_i=1, branchTaken_i=1, pc_i=0x100, immExt_i=0x20 -> next cycle redirect_o=1, target_o=0x120, flushFront_o=1; the following capture has valid_o=0 (squash); branchCount_o=1, takenCount_o=1.
2. JALR with ALUResult_i=0x2003, resultSrc_i=10, rd_i=1, regWrite_i=1 -> target_o=0x2002, redirect_o=1, misalign_o=1... must be reported as misalign_o=1 with no redirect, regWrite_o=0 (0x2002 has bit 1 set).
3. JAL aligned, with stall_i=1 for 3 cycles right after the redirect -> redirect_o stays 1 for all stalled cycles, then drops 1 cycle after stall_i falls; exactly one instruction is squashed.
4. Store with stall_i=1 on its capture edge -> outputs keep the previous values; on release, memWrite_o=1, writeData_o equals the input value, valid_o=1.
5. flush_i=1 while stall_i=1 and valid_o=1 -> next edge valid_o=0, memWrite_o=0, counters unchanged.
6. Preload: 2^32-1 branches (or a reduced CNT_WIDTH=4 build, 15 branches), then one more branch -> branchCount_o wraps to 0. Assert rst mid-cycle -> all outputs 0 asynchronously.
